// File: rtl/eth_tx_arb.sv
// Packet-level round-robin arbiter that merges two 64-bit AXI-Stream sources onto one MAC TX stream.
// The grant is held for a whole packet. Packets longer than MAX_BEATS are cut short, marked bad and drained.
module eth_tx_arb #(
  parameter int MAX_BEATS = 190,
  parameter int CNT_W     = 16
) (
  input  logic             clk156,
  input  logic             eth_rst_n,
  input  logic             tx_enable,

  input  logic             s_axis_p0_tvalid,
  output logic             s_axis_p0_tready,
  input  logic [63:0]      s_axis_p0_tdata,
  input  logic [7:0]       s_axis_p0_tkeep,
  input  logic             s_axis_p0_tlast,
  input  logic             s_axis_p0_tuser,

  input  logic             s_axis_p1_tvalid,
  output logic             s_axis_p1_tready,
  input  logic [63:0]      s_axis_p1_tdata,
  input  logic [7:0]       s_axis_p1_tkeep,
  input  logic             s_axis_p1_tlast,
  input  logic             s_axis_p1_tuser,

  output logic             m_axis_tx0_tvalid,
  input  logic             m_axis_tx0_tready,
  output logic [63:0]      m_axis_tx0_tdata,
  output logic [7:0]       m_axis_tx0_tkeep,
  output logic             m_axis_tx0_tlast,
  output logic             m_axis_tx0_tuser,

  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic [7:0]       trunc_cnt,
  output logic [7:0]       debug
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam int             BW        = $clog2(MAX_BEATS);
  localparam logic [BW-1:0]  LAST_BEAT = BW'(MAX_BEATS - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_grant;
  logic             r_last_grant;
  logic [BW-1:0]    r_beat_cnt;
  logic [CNT_W-1:0] r_pkt_cnt0;
  logic [CNT_W-1:0] r_pkt_cnt1;
  logic [7:0]       r_trunc_cnt;

  logic             w_sel_valid;
  logic             w_sel_last;
  logic             w_sel_user;
  logic [63:0]      w_sel_data;
  logic [7:0]       w_sel_keep;
  logic             w_pick;
  logic             w_any_req;
  logic             w_hs;
  logic             w_trunc_beat;
  logic             w_drop_last;
  logic             w_pkt_done;
  logic             w_pkt_end;

  // Source mux driven only by the registered grant, so the output path has no arbitration logic in it.
  assign w_sel_valid = r_grant ? s_axis_p1_tvalid : s_axis_p0_tvalid;
  assign w_sel_last  = r_grant ? s_axis_p1_tlast  : s_axis_p0_tlast;
  assign w_sel_user  = r_grant ? s_axis_p1_tuser  : s_axis_p0_tuser;
  assign w_sel_data  = r_grant ? s_axis_p1_tdata  : s_axis_p0_tdata;
  assign w_sel_keep  = r_grant ? s_axis_p1_tkeep  : s_axis_p0_tkeep;

  // Prefer the port that did not win last time, else whichever one is requesting.
  assign w_pick    = r_last_grant ? ~s_axis_p0_tvalid : s_axis_p1_tvalid;
  assign w_any_req = s_axis_p0_tvalid | s_axis_p1_tvalid;

  assign w_hs         = (r_state == ST_PASS) && w_sel_valid && m_axis_tx0_tready;
  assign w_trunc_beat = (r_state == ST_PASS) && (r_beat_cnt == LAST_BEAT) && !w_sel_last;
  assign w_drop_last  = (r_state == ST_DROP) && w_sel_valid && w_sel_last;
  assign w_pkt_end    = w_hs && (w_sel_last || w_trunc_beat);
  assign w_pkt_done   = (w_hs && w_sel_last) || w_drop_last;

  // State register
  always_ff @(posedge clk156) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!eth_rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE && w_next_state == ST_PASS) r_grant <= w_pick;
      if (w_pkt_end) r_last_grant <= r_grant;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path assigned, so no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (tx_enable && w_any_req) w_next_state = ST_PASS;
      ST_PASS: begin
        if (w_hs && w_sel_last)        w_next_state = ST_IDLE;
        else if (w_hs && w_trunc_beat) w_next_state = ST_DROP;
      end
      ST_DROP: if (w_drop_last) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    m_axis_tx0_tvalid = 1'b0;
    s_axis_p0_tready  = 1'b0;
    s_axis_p1_tready  = 1'b0;
    case (r_state)
      ST_PASS: begin
        m_axis_tx0_tvalid = w_sel_valid;
        if (r_grant) s_axis_p1_tready = m_axis_tx0_tready;
        else         s_axis_p0_tready = m_axis_tx0_tready;
      end
      ST_DROP: begin
        if (r_grant) s_axis_p1_tready = 1'b1;
        else         s_axis_p0_tready = 1'b1;
      end
      default: ;
    endcase
  end

  assign m_axis_tx0_tdata = w_sel_data;
  assign m_axis_tx0_tkeep = w_sel_keep;
  assign m_axis_tx0_tlast = w_sel_last | w_trunc_beat;
  assign m_axis_tx0_tuser = w_sel_user | w_trunc_beat;

  // Beat position within the packet and the statistics counters
  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      r_beat_cnt  <= '0;
      r_pkt_cnt0  <= '0;
      r_pkt_cnt1  <= '0;
      r_trunc_cnt <= '0;
    end else begin
      if (w_pkt_end)  r_beat_cnt <= '0;
      else if (w_hs)  r_beat_cnt <= r_beat_cnt + BW'(1);

      if (w_pkt_done) begin
        if (r_grant) r_pkt_cnt1 <= r_pkt_cnt1 + CNT_W'(1);
        else         r_pkt_cnt0 <= r_pkt_cnt0 + CNT_W'(1);
      end

      if (w_hs && w_trunc_beat && r_trunc_cnt != 8'hFF) r_trunc_cnt <= r_trunc_cnt + 8'd1;
    end
  end

  assign pkt_cnt0  = r_pkt_cnt0;
  assign pkt_cnt1  = r_pkt_cnt1;
  assign trunc_cnt = r_trunc_cnt;
  assign debug     = {r_state, r_grant, r_last_grant, r_trunc_cnt[3:0]};

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: a default-length instance plus a MAX_BEATS=4 instance for truncation.
// Both instances share the same stimulus; sel picks which one is observed and which one back-pressures the sources.
module tb_eth_tx_arb;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    int          cyc;
  } beat_t;

  logic clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  logic        eth_rst_n, tx_enable, m_tready, sel, tog, gap_chk;
  logic        p0_tvalid, p0_tlast, p0_tuser, p1_tvalid, p1_tlast, p1_tuser;
  logic [63:0] p0_tdata, p1_tdata;
  logic [7:0]  p0_tkeep, p1_tkeep;

  logic        a_p0_tready, a_p1_tready, a_tvalid, a_tlast, a_tuser;
  logic [63:0] a_tdata;
  logic [7:0]  a_tkeep, a_trunc, a_debug;
  logic [15:0] a_pkt0, a_pkt1;
  logic        t_p0_tready, t_p1_tready, t_tvalid, t_tlast, t_tuser;
  logic [63:0] t_tdata;
  logic [7:0]  t_tkeep, t_trunc, t_debug;
  logic [15:0] t_pkt0, t_pkt1;

  logic        w_p0_tready, w_p1_tready, w_tvalid, w_tlast, w_tuser;
  logic [63:0] w_tdata;
  logic [7:0]  w_tkeep;
  assign w_p0_tready = sel ? t_p0_tready : a_p0_tready;
  assign w_p1_tready = sel ? t_p1_tready : a_p1_tready;
  assign w_tvalid    = sel ? t_tvalid    : a_tvalid;
  assign w_tlast     = sel ? t_tlast     : a_tlast;
  assign w_tuser     = sel ? t_tuser     : a_tuser;
  assign w_tdata     = sel ? t_tdata     : a_tdata;
  assign w_tkeep     = sel ? t_tkeep     : a_tkeep;

  eth_tx_arb #(.MAX_BEATS(190), .CNT_W(16)) u_dut (
    .clk156(clk156), .eth_rst_n(eth_rst_n), .tx_enable(tx_enable),
    .s_axis_p0_tvalid(p0_tvalid), .s_axis_p0_tready(a_p0_tready), .s_axis_p0_tdata(p0_tdata),
    .s_axis_p0_tkeep(p0_tkeep), .s_axis_p0_tlast(p0_tlast), .s_axis_p0_tuser(p0_tuser),
    .s_axis_p1_tvalid(p1_tvalid), .s_axis_p1_tready(a_p1_tready), .s_axis_p1_tdata(p1_tdata),
    .s_axis_p1_tkeep(p1_tkeep), .s_axis_p1_tlast(p1_tlast), .s_axis_p1_tuser(p1_tuser),
    .m_axis_tx0_tvalid(a_tvalid), .m_axis_tx0_tready(m_tready), .m_axis_tx0_tdata(a_tdata),
    .m_axis_tx0_tkeep(a_tkeep), .m_axis_tx0_tlast(a_tlast), .m_axis_tx0_tuser(a_tuser),
    .pkt_cnt0(a_pkt0), .pkt_cnt1(a_pkt1), .trunc_cnt(a_trunc), .debug(a_debug)
  );

  eth_tx_arb #(.MAX_BEATS(4), .CNT_W(16)) u_dut_trunc (
    .clk156(clk156), .eth_rst_n(eth_rst_n), .tx_enable(tx_enable),
    .s_axis_p0_tvalid(p0_tvalid), .s_axis_p0_tready(t_p0_tready), .s_axis_p0_tdata(p0_tdata),
    .s_axis_p0_tkeep(p0_tkeep), .s_axis_p0_tlast(p0_tlast), .s_axis_p0_tuser(p0_tuser),
    .s_axis_p1_tvalid(p1_tvalid), .s_axis_p1_tready(t_p1_tready), .s_axis_p1_tdata(p1_tdata),
    .s_axis_p1_tkeep(p1_tkeep), .s_axis_p1_tlast(p1_tlast), .s_axis_p1_tuser(p1_tuser),
    .m_axis_tx0_tvalid(t_tvalid), .m_axis_tx0_tready(m_tready), .m_axis_tx0_tdata(t_tdata),
    .m_axis_tx0_tkeep(t_tkeep), .m_axis_tx0_tlast(t_tlast), .m_axis_tx0_tuser(t_tuser),
    .pkt_cnt0(t_pkt0), .pkt_cnt1(t_pkt1), .trunc_cnt(t_trunc), .debug(t_debug)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    n_mvalid, mirror_err, p1_rdy_seen, seen_src_cyc, seen_m_cyc;
  logic  s_mv;
  beat_t q0[$], q1[$], out_log[$], exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input int port, input int pkt, input int idx, input int n);
    beat_t b;
    b.data = {port[7:0], pkt[7:0], 48'(idx)};
    b.keep = (idx == n - 1) ? 8'h0F : 8'hFF;
    b.last = (idx == n - 1);
    b.user = 1'b0;
    b.cyc  = 0;
    return b;
  endfunction

  task automatic push_pkt(input int port, input int pkt, input int n);
    for (int i = 0; i < n; i++) begin
      if (port == 1) q1.push_back(mk(port, pkt, i, n));
      else           q0.push_back(mk(port, pkt, i, n));
    end
  endtask

  task automatic add_exp(input int port, input int pkt, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(port, pkt, i, n));
  endtask

  task automatic drive();
    p0_tvalid = (q0.size() != 0);
    p1_tvalid = (q1.size() != 0);
    if (q0.size() != 0) {p0_tdata, p0_tkeep, p0_tlast, p0_tuser} = {q0[0].data, q0[0].keep, q0[0].last, q0[0].user};
    else                {p0_tdata, p0_tkeep, p0_tlast, p0_tuser} = '0;
    if (q1.size() != 0) {p1_tdata, p1_tkeep, p1_tlast, p1_tuser} = {q1[0].data, q1[0].keep, q1[0].last, q1[0].user};
    else                {p1_tdata, p1_tkeep, p1_tlast, p1_tuser} = '0;
  endtask

  // One clock: observe at the falling edge, advance sources just after the rising edge.
  task automatic step();
    logic  f0, f1;
    beat_t b;
    @(negedge clk156);
    s_mv = w_tvalid;
    if (w_tvalid) n_mvalid++;
    if (w_tvalid && m_tready) begin
      b = '{data: w_tdata, keep: w_tkeep, last: w_tlast, user: w_tuser, cyc: cyc};
      out_log.push_back(b);
    end
    if (w_tvalid && (w_p1_tready !== m_tready)) mirror_err++;
    if (w_p1_tready) p1_rdy_seen++;
    if (seen_src_cyc < 0 && p0_tvalid) seen_src_cyc = cyc;
    if (seen_m_cyc < 0 && w_tvalid)    seen_m_cyc   = cyc;
    f0 = p0_tvalid && w_p0_tready;
    f1 = p1_tvalid && w_p1_tready;
    @(posedge clk156);
    #1;
    if (f0) void'(q0.pop_front());
    if (f1) void'(q1.pop_front());
    if (tog) m_tready = !m_tready;
    drive();
    cyc++;
  endtask

  task automatic clear_obs();
    out_log.delete();
    exp_q.delete();
    n_mvalid     = 0;
    mirror_err   = 0;
    p1_rdy_seen  = 0;
    seen_src_cyc = -1;
    seen_m_cyc   = -1;
  endtask

  task automatic do_reset();
    eth_rst_n = 1'b0;
    q0.delete();
    q1.delete();
    drive();
    repeat (2) step();
    eth_rst_n = 1'b1;
    clear_obs();
  endtask

  task automatic run(input string tag, input int n, input int max_cyc, input bit wait_q);
    int k = 0;
    while ((out_log.size() < n || (wait_q && (q0.size() != 0 || q1.size() != 0))) && k < max_cyc) begin
      step();
      k++;
    end
    check({tag, "_done"}, 64'(k < max_cyc), 64'd1);
  endtask

  task automatic cmp_log(input string tag);
    check({tag, "_n"}, 64'(out_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < out_log.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_d%0d", tag, i), out_log[i].data, exp_q[i].data);
      check($sformatf("%s_c%0d", tag, i), {out_log[i].keep, out_log[i].last, out_log[i].user},
                                          {exp_q[i].keep, exp_q[i].last, exp_q[i].user});
      if (gap_chk && i > 0 && out_log[i-1].last)
        check($sformatf("%s_g%0d", tag, i), 64'(out_log[i].cyc - out_log[i-1].cyc), 64'd2);
    end
  endtask

  initial begin
    beat_t b;
    int    k;
    sel = 1'b0; tog = 1'b0; gap_chk = 1'b0;
    tx_enable = 1'b1; m_tready = 1'b1;
    do_reset();

    check("rst_p0_rdy", a_p0_tready, 0);
    check("rst_p1_rdy", a_p1_tready, 0);
    check("rst_mvalid", a_tvalid, 0);
    check("rst_cnt", {a_pkt0, a_pkt1, a_trunc}, 0);
    check("rst_debug", a_debug, 8'h10);

    // Single 3-beat packet from p0; one arbitration bubble before the first beat.
    push_pkt(0, 1, 3);
    add_exp(0, 1, 3);
    drive();
    run("t1", 3, 50, 1);
    cmp_log("t1");
    check("t1_lat", 64'(seen_m_cyc - seen_src_cyc), 64'd1);
    check("t1_pkt0", a_pkt0, 1);
    check("t1_p1rdy", 64'(p1_rdy_seen), 0);

    // Both ports hold two 4-beat packets: strict alternation, one idle cycle between packets.
    do_reset();
    gap_chk = 1'b1;
    push_pkt(0, 2, 4); push_pkt(0, 3, 4);
    push_pkt(1, 4, 4); push_pkt(1, 5, 4);
    add_exp(0, 2, 4); add_exp(1, 4, 4); add_exp(0, 3, 4); add_exp(1, 5, 4);
    drive();
    run("t2", 16, 100, 1);
    cmp_log("t2");
    check("t2_pkt0", a_pkt0, 2);
    check("t2_pkt1", a_pkt1, 2);
    gap_chk = 1'b0;

    // Back-pressure alternating every cycle during a 5-beat p1 packet.
    do_reset();
    tog = 1'b1;
    push_pkt(1, 6, 5);
    add_exp(1, 6, 5);
    drive();
    run("t3", 5, 100, 1);
    tog = 1'b0;
    m_tready = 1'b1;
    cmp_log("t3");
    check("t3_mirror", 64'(mirror_err), 0);
    check("t3_pkt1", a_pkt1, 1);

    // MAX_BEATS=4: a 7-beat p0 packet is cut at beat 4, then an exactly-4-beat p1 packet passes intact.
    sel = 1'b1;
    do_reset();
    push_pkt(0, 7, 7);
    push_pkt(1, 8, 4);
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(0, 7, i, 7));
    b = mk(0, 7, 3, 7);
    b.last = 1'b1;
    b.user = 1'b1;
    exp_q.push_back(b);
    add_exp(1, 8, 4);
    drive();
    run("t4", 8, 100, 1);
    cmp_log("t4");
    check("t4_mvalid", 64'(n_mvalid), 64'd8);
    check("t4_trunc", t_trunc, 1);
    check("t4_pkt0", t_pkt0, 1);
    check("t4_pkt1", t_pkt1, 1);
    check("t4_debug", t_debug, 8'h31);
    sel = 1'b0;

    // tx_enable dropped after the first beat: packet completes, then no grant until re-enabled.
    do_reset();
    push_pkt(0, 10, 3);
    push_pkt(1, 11, 2);
    add_exp(0, 10, 3);
    add_exp(1, 11, 2);
    drive();
    k = 0;
    while (out_log.size() < 1 && k < 50) begin step(); k++; end
    tx_enable = 1'b0;
    while (out_log.size() < 3 && k < 100) begin step(); k++; end
    check("t5_pkt0", a_pkt0, 1);
    n_mvalid = 0;
    repeat (5) step();
    check("t5_idle", 64'(n_mvalid), 0);
    check("t5_hold", 64'(q1.size()), 64'd2);
    tx_enable = 1'b1;
    step();
    check("t5_arb", s_mv, 0);
    step();
    check("t5_grant", s_mv, 1);
    run("t5", 5, 50, 1);
    cmp_log("t5");
    check("t5_pkt1", a_pkt1, 1);

    // Reset pulse while beat 2 of a p0 packet is on the bus.
    push_pkt(0, 12, 4);
    drive();
    k = 0;
    while (out_log.size() < 1 && k < 50) begin step(); k++; end
    eth_rst_n = 1'b0;
    step();
    eth_rst_n = 1'b1;
    q0.delete();
    q1.delete();
    drive();
    check("t6_p0_rdy", a_p0_tready, 0);
    check("t6_p1_rdy", a_p1_tready, 0);
    check("t6_mvalid", a_tvalid, 0);
    check("t6_cnt", {a_pkt0, a_pkt1, a_trunc}, 0);
    check("t6_debug", a_debug, 8'h10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
